// File: rtl/sram_like_responder.sv
// Slave end of the SRAM-like req/addr_ok/data_ok bus: byte-lane access on an
// internal word array at acceptance, in-order responses after a fixed latency.
module sram_like_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]           mem     [2**ADDR_WIDTH];
  logic [31:0]           q_data  [DEPTH];
  logic [3:0]            q_timer [DEPTH];
  logic [DEPTH-1:0]      q_valid;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            byte_en;
  logic                  accept;
  logic                  head_ready;
  logic                  unused_addr;

  // Upper address bits alias onto the array.
  assign word_idx    = addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    lane_en = 4'b0001 << off;
      2'd1:    lane_en = off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
      2'd2:    lane_en = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full queue blocks acceptance even when the head pops this cycle.
  assign addr_ok    = !reset && (count < CNT_W'(DEPTH));
  assign accept     = req && addr_ok;
  assign byte_en    = wr ? lane_en(size, addr[1:0]) : 4'b0000;
  assign head_ready = q_valid[rd_ptr] && (q_timer[rd_ptr] == 4'd0);
  assign data_ok    = !reset && head_ready;
  assign rdata      = data_ok ? q_data[rd_ptr] : 32'h0;

  // NOTE: the array and queued data carry no reset; only control state does,
  // which keeps the array a plain inferable RAM and preserves committed stores.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_data[wr_ptr] <= mem[word_idx];
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // NOTE: all state uses non-blocking assignment, so the captured word above
  // is the pre-write value and later assignments here override earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) q_timer[i] <= 4'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && q_timer[i] != 4'd0) q_timer[i] <= q_timer[i] - 4'd1;
      end
      if (data_ok) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_next(rd_ptr);
      end
      if (accept) begin
        q_valid[wr_ptr] <= 1'b1;
        q_timer[wr_ptr] <= 4'(LATENCY - 1);
        wr_ptr          <= ptr_next(wr_ptr);
      end
      case ({accept, data_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: LATENCY=2/DEPTH=2 instance for data
// paths, LATENCY=4/DEPTH=2 instance for the held-request flow-control pattern.
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req4, wr4;
  logic [31:0] addr4, wdata4;
  logic        addr_ok4, data_ok4;
  logic [31:0] rdata4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_like_responder #(.ADDR_WIDTH(12), .LATENCY(2), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_responder #(.ADDR_WIDTH(12), .LATENCY(4), .DEPTH(2)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .wr(wr4), .size(2'd2), .addr(addr4),
    .wdata(wdata4), .addr_ok(addr_ok4), .data_ok(data_ok4), .rdata(rdata4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One request, then wait (bounded) for its response and optionally check rdata.
  task automatic op(input string tag, input logic w, input logic [1:0] s,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic chk, input logic [31:0] exp);
    logic found;
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    @(negedge clk);
    check({tag, "_aok"}, addr_ok, 1);
    next_cycle();
    req = 1'b0; wr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (data_ok) begin
        found = 1'b1;
        if (chk) check(tag, rdata, exp);
      end
      next_cycle();
    end
    if (!found) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [10:0] exp_ao, exp_do;
    int k, resp, seen;

    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = '0; wdata = '0;
    req4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
    next_cycle();
    @(negedge clk);
    check("rst_addr_ok", addr_ok, 0);
    check("rst_data_ok", data_ok, 0);
    check("rst_rdata", rdata, 0);
    next_cycle();
    reset = 1'b0;

    // Test 1: store then load, exact cycle timing at LATENCY=2.
    op("pre10", 1'b1, 2'd2, 32'h10, 32'h0BADF00D, 1'b0, 32'h0);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_c0_aok", addr_ok, 1);
    check("t1_c0_dok", data_ok, 0);
    next_cycle();
    wr = 1'b0;
    @(negedge clk);
    check("t1_c1_aok", addr_ok, 1);
    check("t1_c1_dok", data_ok, 0);
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    check("t1_c2_dok", data_ok, 1);
    check("t1_c2_rdata", rdata, 32'h0BADF00D);
    next_cycle();
    @(negedge clk);
    check("t1_c3_dok", data_ok, 1);
    check("t1_c3_rdata", rdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("t1_c4_dok", data_ok, 0);
    check("t1_c4_rdata", rdata, 0);
    next_cycle();

    // Test 2: byte and halfword lanes merge into a word.
    op("t2_w",    1'b1, 2'd2, 32'h20, 32'h11223344, 1'b0, 32'h0);
    op("t2_b",    1'b1, 2'd0, 32'h22, 32'h00AA0000, 1'b1, 32'h11223344);
    op("t2_h",    1'b1, 2'd1, 32'h20, 32'h0000BBCC, 1'b1, 32'h11AA3344);
    op("t2_load", 1'b0, 2'd2, 32'h20, 32'h0,        1'b1, 32'h11AABBCC);

    // Test 4: misaligned and reserved-size stores leave the word unchanged.
    op("t4_w",    1'b1, 2'd2, 32'h40, 32'h12345678, 1'b0, 32'h0);
    op("t4_mw",   1'b1, 2'd2, 32'h42, 32'hFFFFFFFF, 1'b1, 32'h12345678);
    op("t4_mh",   1'b1, 2'd1, 32'h41, 32'hFFFFFFFF, 1'b1, 32'h12345678);
    op("t4_s3",   1'b1, 2'd3, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h12345678);
    op("t4_load", 1'b0, 2'd2, 32'h40, 32'h0,        1'b1, 32'h12345678);
    op("t4_hi_h", 1'b1, 2'd1, 32'h42, 32'h99990000, 1'b1, 32'h12345678);
    op("t4_load2",1'b0, 2'd2, 32'h40, 32'h0,        1'b1, 32'h99995678);

    // Test 5: aliasing above the array size.
    op("t5_st",   1'b1, 2'd2, 32'h0,    32'h5, 1'b0, 32'h0);
    op("t5_alias",1'b0, 2'd2, 32'h4000, 32'h0, 1'b1, 32'h5);

    // Test 3: held requests, LATENCY=4 DEPTH=2; pass 0 stores, pass 1 loads.
    exp_ao = 11'b10001100011;
    exp_do = 11'b11000110000;
    for (int pass = 0; pass < 2; pass++) begin
      k = 0; resp = 0;
      for (int cyc = 0; cyc < 11; cyc++) begin
        req4 = (k < 4); wr4 = (pass == 0);
        addr4 = 32'(k * 4); wdata4 = 32'hA0 + 32'(k);
        @(negedge clk);
        check($sformatf("t3_p%0d_c%0d_aok", pass, cyc), addr_ok4, exp_ao[cyc]);
        check($sformatf("t3_p%0d_c%0d_dok", pass, cyc), data_ok4, exp_do[cyc]);
        if (pass == 1 && data_ok4) begin
          check($sformatf("t3_rdata%0d", resp), rdata4, 32'hA0 + 32'(resp));
          resp++;
        end
        if (req4 && addr_ok4) k++;
        next_cycle();
      end
      req4 = 1'b0; wr4 = 1'b0;
      repeat (6) next_cycle();
    end

    // Test 6: reset with two outstanding stores; stores stay committed.
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h80; wdata = 32'hCAFE0001;
    next_cycle();
    addr = 32'h84; wdata = 32'h00001234;
    next_cycle();
    req = 1'b0; wr = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t6_rst_dok", data_ok, 0);
    check("t6_rst_aok", addr_ok, 0);
    next_cycle();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_ok) seen++;
      next_cycle();
    end
    check("t6_no_resp", seen, 0);
    op("t6_ld80", 1'b0, 2'd2, 32'h80, 32'h0, 1'b1, 32'hCAFE0001);
    op("t6_ld84", 1'b0, 2'd2, 32'h84, 32'h0, 1'b1, 32'h00001234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Memory-side responder for the CPU's SRAM-like data bus: the slave end of the req/addr_ok/data_ok handshake that the pipeline issues loads and stores on.
- Accepts address phases, performs the byte-lane access on an internal word array at acceptance, and returns responses in order after a fixed latency.
- Replaces the single-cycle data RAM so the CPU's multi-cycle memory path can be exercised; supports several outstanding requests.

Parameters:
- ADDR_WIDTH, 12, word-address bits; array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from acceptance cycle to data_ok cycle; legal range 1..15.
- DEPTH, 2, maximum outstanding (accepted, not yet responded) requests; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  master requests an address phase this cycle.
- wr  in  1  1 = store, 0 = load; qualified by req.
- size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- addr  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word, higher bits ignored (aliasing).
- wdata  in  32  store data, byte lanes aligned to addr (byte at addr[1:0]=n is wdata[8n+7:8n]).
- addr_ok  out  1  address phase accepted this cycle.
- data_ok  out  1  response for the oldest outstanding request valid this cycle.
- rdata  out  32  full word read for the responding request; 0 when data_ok low.

Behaviour:
- Reset: queue emptied, all timers cleared; addr_ok=0, data_ok=0, rdata=0 during and after the reset cycle. Array contents not reset. Reset mid-operation discards all outstanding responses; stores already accepted stay committed.
- addr_ok = !reset && (count < DEPTH), combinational; independent of req. Acceptance = req && addr_ok at a rising edge.
- Acceptance edge (one combined action):
  - read the addressed word, then apply store lanes if wr;
  - the entry stores the pre-write word (read-before-write), giving strict program-order visibility;
  - push {data, timer = LATENCY-1}.
- Each cycle, every valid entry with timer > 0 decrements.
- data_ok = head valid && head timer == 0; rdata = head data. The head pops at the end of that cycle. Exactly one response per cycle max; responses strictly in acceptance order. No data-phase backpressure: the master must take data_ok when presented.
- LATENCY=1: request accepted in cycle N responds in cycle N+1. General: response in cycle N+LATENCY, or later if an older response is pending.
- Store lane enables:
  - size 0: one lane, addr[1:0];
  - size 1: lanes {addr[1],0} and {addr[1],1}, only if addr[0]=0;
  - size 2: all four lanes, only if addr[1:0]=0.
  - Misaligned or size 3: accepted, no array write, response still returned (read word).
- Loads: rdata always the full word; extension and lane selection are the master's job.
- Simultaneous pop and accept in one cycle: both happen; count unchanged. Full (count==DEPTH): addr_ok low even if a pop occurs that cycle (no same-cycle slot reuse).
- Queue pointers wrap modulo DEPTH; count saturates neither way (illegal over/underflow cannot occur by construction).
- Back-to-back accepts to the same word: second sees first's write.

Test Plan:
- Reset then word store addr=0x10, wdata=0xDEADBEEF, followed by word load addr=0x10 (LATENCY=2) -> addr_ok both cycles, data_ok in cycles 2 and 3 after first accept, second rdata=0xDEADBEEF; first rdata = pre-write contents.
- After word store 0x11223344 @0x20: byte store 0xAA in lane 2 (addr=0x22, wdata=0x00AA0000), halfword store 0xBBCC @0x20 (wdata=0x0000BBCC), word load @0x20 -> rdata=0x11AABBCC.
- DEPTH=2, LATENCY=4, req held high with loads -> addr_ok high 2 cycles, low until first data_ok cycle passes, then refills; data_ok sequence in order, never two per cycle.
- Misaligned word store 0xFFFFFFFF @0x42 and halfword @0x41 -> both accepted and responded, word @0x40 unchanged on readback.
- Aliasing: store 0x5 to 0x0, load from 0x1<<(ADDR_WIDTH+2) -> rdata=0x5.
- Reset asserted with 2 outstanding -> no data_ok after reset; later load of a stored-then-reset address returns the committed value.
